if_fetch_buffer: RTL and testbench
==================================

// Module: if_fetch_buffer
// PURPOSE
//  Instruction-fetch stage that feeds ID: owns the PC and issues in-order requests to instruction ROM.
//  Buffers returned words with their PCs in a small FIFO and presents one instruction per cycle to ID.
//  Supports ID stall, and flush/redirect from branch resolution. Stale in-flight responses are discarded after a flush.
// PARAMETERS
//  RESET_PC    32'hBFC0_0000  PC of first fetch after reset
//  FIFO_DEPTH  4              instruction buffer entries (power of 2, >=2); also max in-flight requests
// PORTS
//  clk         in   1   clock
//  rst         in   1   reset, synchronous, active-high
//  stall       in   1   ID cannot accept this cycle
//  flush       in   1   redirect fetch to flush_pc
//  flush_pc    in   32  redirect target
//  rom_req     out  1   fetch request valid
//  rom_addr    out  32  fetch address (= pc)
//  rom_gnt     in   1   request accepted this cycle
//  rom_rvalid  in   1   response data valid (in order, >=1 cycle after gnt)
//  rom_rdata   in   32  response instruction word
//  inst_valid  out  1   inst/inst_pc valid to ID
//  inst        out  32  instruction to ID (32'h0 when !inst_valid)
//  inst_pc     out  32  PC of inst (32'h0 when !inst_valid)
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): pc<=RESET_PC, fifo count/ptrs<=0, outstanding<=0, drop_cnt<=0.
//    While rst=1: rom_req=0, inst_valid=0, inst=0, inst_pc=0.
//  - Issue: rom_req = !rst && !flush && (count+outstanding < FIFO_DEPTH); rom_addr = pc.
//    On rom_req&&rom_gnt: pc<=pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0); outstanding+1.
//  - Response: each rom_rvalid decrements outstanding.
//    If drop_cnt>0: the word is discarded and drop_cnt decrements.
//    Else, if !flush: push {pc_of_req, rom_rdata} into the FIFO.
//    The request PC travels via an in-flight PC queue of FIFO_DEPTH entries.
//  - Credit rule guarantees no FIFO overflow; rom_rvalid with outstanding==0 is illegal (assert).
//  - Output: inst_valid = count!=0; inst/inst_pc = FIFO head. Pop when inst_valid && !stall && !flush.
//    Push and pop in the same cycle are allowed, including at count==FIFO_DEPTH-1 and count==1.
//  - Latency: gnt in cycle t, rvalid in cycle t+k -> inst_valid in cycle t+k+1 (no bypass).
//    Full throughput requires k+1 <= FIFO_DEPTH.
//  - Flush (priority over all except rst):
//    * FIFO cleared, no pop, no request.
//    * pc <= {flush_pc[31:2],2'b00}.
//    * drop_cnt <= outstanding minus 1 if an rvalid arrives this cycle; that word is itself dropped.
//    * Previously nonzero drop_cnt is folded into the same count.
//    * First instruction presented after the flush carries inst_pc = aligned flush_pc.
//  - stall affects only popping; fetch continues until credit is exhausted.
//  - Mid-operation rst: in-flight responses are not tracked and the ROM must be reset together with this block.
// TESTING
//  1. rst=1 for 3 cycles, rom_gnt=1 -> rom_req=0, inst_valid=0, inst=0; cycle after release: rom_req=1, rom_addr=BFC00000.
//  2. gnt=1, 1-cycle ROM, stall=0 -> inst_valid continuous from 3rd cycle; inst_pc BFC00000, BFC00004, BFC00008...; data matches ROM.
//  3. stall=1 for 8 cycles during streaming -> FIFO holds 4 entries, rom_req drops; after release, PCs continue with no gap or duplicate.
//  4. ROM latency 3, 2 in flight, flush_pc=80001003 -> both stale words dropped; next inst_pc=80001000; next rom_addr=80001000.
//  5. flush in same cycle as rom_rvalid and pop -> that word dropped, drop_cnt=outstanding-1, no entry popped twice.
//  6. flush_pc=FFFFFFFC -> rom_addr FFFFFFFC then 00000000; inst_pc sequence wraps identically.

Source files
------------

// File: rtl/if_fetch_buffer_if.sv
// Fetch-stage bundle: instruction ROM request/response channel plus the
// instruction handoff to ID and the control inputs from ID/branch resolution.
interface if_fetch_buffer_if;
   logic        stall;
   logic        flush;
   logic [31:0] flush_pc;
   logic        rom_req;
   logic [31:0] rom_addr;
   logic        rom_gnt;
   logic        rom_rvalid;
   logic [31:0] rom_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;

   // Fetch block side: issues ROM requests, presents instructions to ID
   modport master (
      input  stall, flush, flush_pc, rom_gnt, rom_rvalid, rom_rdata,
      output rom_req, rom_addr, inst_valid, inst, inst_pc
   );

   // Environment side: ROM, ID stage and branch unit
   modport slave (
      output stall, flush, flush_pc, rom_gnt, rom_rvalid, rom_rdata,
      input  rom_req, rom_addr, inst_valid, inst, inst_pc
   );
endinterface

// File: rtl/if_fetch_buffer.sv
// Instruction-fetch stage: owns the PC, issues in-order ROM requests under a
// credit limit, buffers returned words with their PCs and hands one per cycle
// to ID. A flush redirects the PC and discards every response still in flight.
module if_fetch_buffer #(
   parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input logic               clk,
   input logic               rst,
   if_fetch_buffer_if.master bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] out_q, out_d;       // requests granted but not yet answered
   logic [CW-1:0] drop_q, drop_d;     // in-flight responses to throw away
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] ifq_wr_q, ifq_wr_d;
   logic [AW-1:0] ifq_rd_q, ifq_rd_d;

   logic [31:0] fifo_pc_mem   [FIFO_DEPTH];
   logic [31:0] fifo_data_mem [FIFO_DEPTH];
   logic [31:0] ifq_mem       [FIFO_DEPTH]; // PC of each in-flight request

   logic [CW:0] credit_sum;
   logic        req, issue, rsp, dropping, push, pop, valid;

   // Handshake decode: credit covers both buffered and in-flight words so a
   // response always has a FIFO slot waiting for it.
   always_comb begin
      credit_sum = {1'b0, count_q} + {1'b0, out_q};
      req        = !rst && !bus.flush && (credit_sum < DEPTH_W);
      issue      = req && bus.rom_gnt;
      rsp        = !rst && bus.rom_rvalid;
      dropping   = rsp && (drop_q != '0);
      push       = rsp && !dropping && !bus.flush;
      valid      = !rst && (count_q != '0);
      pop        = valid && !bus.stall && !bus.flush;
   end

   // Next-state: flush clears the FIFO and marks every outstanding response
   // (minus one arriving right now, which is simply not pushed) for dropping.
   always_comb begin
      pc_d     = issue ? pc_q + 32'd4 : pc_q;
      out_d    = out_q + CW'(issue) - CW'(rsp);
      drop_d   = dropping ? drop_q - CW'(1) : drop_q;
      count_d  = count_q + CW'(push) - CW'(pop);
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      ifq_wr_d = issue ? ifq_wr_q + AW'(1) : ifq_wr_q;
      ifq_rd_d = rsp   ? ifq_rd_q + AW'(1) : ifq_rd_q;
      if (bus.flush) begin
         pc_d     = bus.flush_pc & 32'hFFFF_FFFC;
         drop_d   = out_q - CW'(rsp);
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
   end

   // Control state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         count_q  <= '0;
         out_q    <= '0;
         drop_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ifq_wr_q <= '0;
         ifq_rd_q <= '0;
      end else begin
         pc_q     <= pc_d;
         count_q  <= count_d;
         out_q    <= out_d;
         drop_q   <= drop_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ifq_wr_q <= ifq_wr_d;
         ifq_rd_q <= ifq_rd_d;
      end
   end

   // Storage: in-flight PC queue and the instruction buffer
   always_ff @(posedge clk) begin
      if (issue) begin
         ifq_mem[ifq_wr_q] <= pc_q;
      end
      if (push) begin
         fifo_pc_mem[wr_ptr_q]   <= ifq_mem[ifq_rd_q];
         fifo_data_mem[wr_ptr_q] <= bus.rom_rdata;
      end
   end

   assign bus.rom_req    = req;
   assign bus.rom_addr   = pc_q;
   assign bus.inst_valid = valid;
   assign bus.inst       = valid ? fifo_data_mem[rd_ptr_q] : 32'h0;
   assign bus.inst_pc    = valid ? fifo_pc_mem[rd_ptr_q]   : 32'h0;

   // A response with nothing outstanding means the ROM is out of sync
   a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
      !(bus.rom_rvalid && out_q == '0));

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Directed bench for if_fetch_buffer: a fixed-latency ROM model, a vector
// table for reset/streaming/stall, and hand sequences for flush corners.
module tb_if_fetch_buffer;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   if_fetch_buffer_if bus();

   if_fetch_buffer #(.RESET_PC(32'hBFC0_0000), .FIFO_DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        rst;
      logic        stall;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vecs[22];

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   int lat      = 1;

   logic [31:0] q_addr[$];
   int          q_due[$];

   logic        cap_req, cap_valid;
   logic [31:0] cap_addr, cap_inst, cap_pc;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return a ^ 32'h5A3C_96E1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock: present due ROM response, sample outputs, record grant, clock.
   task automatic cycle();
      if (rst) begin
         q_addr.delete();
         q_due.delete();
         bus.rom_rvalid = 1'b0;
         bus.rom_rdata  = 32'h0;
      end else if (q_due.size() > 0 && q_due[0] == cyc) begin
         bus.rom_rvalid = 1'b1;
         bus.rom_rdata  = rom_word(q_addr[0]);
         void'(q_addr.pop_front());
         void'(q_due.pop_front());
      end else begin
         bus.rom_rvalid = 1'b0;
         bus.rom_rdata  = 32'h0;
      end
      #1;
      cap_req   = bus.rom_req;
      cap_addr  = bus.rom_addr;
      cap_valid = bus.inst_valid;
      cap_inst  = bus.inst;
      cap_pc    = bus.inst_pc;
      if (cap_req && bus.rom_gnt) begin
         q_addr.push_back(cap_addr);
         q_due.push_back(cyc + lat);
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset(input int l);
      lat       = l;
      rst       = 1'b1;
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      repeat (2) cycle();
      rst = 1'b0;
   endtask

   // Run unstalled until n instructions popped, checking PC order and data.
   task automatic run_stream(input logic [31:0] start, input int n, input string tag);
      logic [31:0] exp_pc;
      int got;
      int budget;
      exp_pc = start;
      got    = 0;
      budget = 40;
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      while (got < n && budget > 0) begin
         cycle();
         budget--;
         if (cap_valid) begin
            $display("%s: inst_pc=%h inst=%h", tag, cap_pc, cap_inst);
            chk($sformatf("%s.pc%0d", tag, got), cap_pc, exp_pc);
            chk($sformatf("%s.inst%0d", tag, got), cap_inst, rom_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            got++;
         end
      end
      n_checks++;
      if (got < n) begin
         n_err++;
         $display("FAIL %s.timeout: got %0d instructions, required %0d", tag, got, n);
      end
   endtask

   localparam logic [31:0] B = 32'hBFC0_0000;

   initial begin
      rst            = 1'b1;
      bus.stall      = 1'b0;
      bus.flush      = 1'b0;
      bus.flush_pc   = 32'h0;
      bus.rom_gnt    = 1'b1;
      bus.rom_rvalid = 1'b0;
      bus.rom_rdata  = 32'h0;

      // rst, stall, req, addr, valid, pc  (1-cycle ROM, gnt always high)
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, B,         1'b0, 32'h0};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, B+32'h04,  1'b0, 32'h0};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, B+32'h08,  1'b1, B};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, B+32'h0C,  1'b1, B+32'h04};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, B+32'h10,  1'b1, B+32'h08};
      vecs[8]  = '{1'b0, 1'b1, 1'b1, B+32'h14,  1'b1, B+32'h0C};
      vecs[9]  = '{1'b0, 1'b1, 1'b1, B+32'h18,  1'b1, B+32'h0C};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0,     1'b1, B+32'h0C};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0,     1'b1, B+32'h0C};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h0,     1'b1, B+32'h0C};
      vecs[13] = '{1'b0, 1'b1, 1'b0, 32'h0,     1'b1, B+32'h0C};
      vecs[14] = '{1'b0, 1'b1, 1'b0, 32'h0,     1'b1, B+32'h0C};
      vecs[15] = '{1'b0, 1'b1, 1'b0, 32'h0,     1'b1, B+32'h0C};
      vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b1, B+32'h0C};
      vecs[17] = '{1'b0, 1'b0, 1'b1, B+32'h1C,  1'b1, B+32'h10};
      vecs[18] = '{1'b0, 1'b0, 1'b1, B+32'h20,  1'b1, B+32'h14};
      vecs[19] = '{1'b0, 1'b0, 1'b1, B+32'h24,  1'b1, B+32'h18};
      vecs[20] = '{1'b0, 1'b0, 1'b1, B+32'h28,  1'b1, B+32'h1C};
      vecs[21] = '{1'b0, 1'b0, 1'b1, B+32'h2C,  1'b1, B+32'h20};

      lat = 1;
      for (int i = 0; i < 22; i++) begin
         rst       = vecs[i].rst;
         bus.stall = vecs[i].stall;
         cycle();
         $display("vec %0d: rst=%0b stall=%0b req=%0b addr=%h valid=%0b pc=%h inst=%h",
                  i, vecs[i].rst, vecs[i].stall, cap_req, cap_addr, cap_valid, cap_pc, cap_inst);
         chk($sformatf("v%0d.req", i), 32'(cap_req), 32'(vecs[i].exp_req));
         if (vecs[i].exp_req)
            chk($sformatf("v%0d.addr", i), cap_addr, vecs[i].exp_addr);
         chk($sformatf("v%0d.valid", i), 32'(cap_valid), 32'(vecs[i].exp_valid));
         chk($sformatf("v%0d.pc", i), cap_pc, vecs[i].exp_pc);
         chk($sformatf("v%0d.inst", i), cap_inst,
             vecs[i].exp_valid ? rom_word(vecs[i].exp_pc) : 32'h0);
      end

      // Latency 3, two requests in flight when the flush hits
      do_reset(3);
      cycle();
      cycle();
      bus.flush    = 1'b1;
      bus.flush_pc = 32'h8000_1003;
      cycle();
      $display("t4 flush: req=%0b valid=%0b", cap_req, cap_valid);
      chk("t4.flush_req", 32'(cap_req), 32'h0);
      bus.flush = 1'b0;
      cycle();
      $display("t4 redirect: req=%0b addr=%h", cap_req, cap_addr);
      chk("t4.req", 32'(cap_req), 32'h1);
      chk("t4.addr", cap_addr, 32'h8000_1000);
      chk("t4.valid", 32'(cap_valid), 32'h0);
      run_stream(32'h8000_1000, 3, "t4");

      // Latency 2: flush coincides with an arriving word and a would-be pop
      do_reset(2);
      run_stream(B, 3, "t5pre");
      bus.flush    = 1'b1;
      bus.flush_pc = 32'h0000_1234;
      cycle();
      $display("t5 flush: valid=%0b pc=%h req=%0b", cap_valid, cap_pc, cap_req);
      chk("t5.valid_at_flush", 32'(cap_valid), 32'h1);
      chk("t5.flush_req", 32'(cap_req), 32'h0);
      bus.flush = 1'b0;
      cycle();
      chk("t5.req", 32'(cap_req), 32'h1);
      chk("t5.addr", cap_addr, 32'h0000_1234);
      chk("t5.empty1", 32'(cap_valid), 32'h0);
      cycle();
      chk("t5.empty2", 32'(cap_valid), 32'h0);
      cycle();
      chk("t5.empty3", 32'(cap_valid), 32'h0);
      run_stream(32'h0000_1234, 3, "t5");

      // PC wrap at the top of the address space
      do_reset(1);
      run_stream(B, 2, "t6pre");
      bus.flush    = 1'b1;
      bus.flush_pc = 32'hFFFF_FFFC;
      cycle();
      bus.flush = 1'b0;
      cycle();
      $display("t6: req=%0b addr=%h", cap_req, cap_addr);
      chk("t6.req0", 32'(cap_req), 32'h1);
      chk("t6.addr0", cap_addr, 32'hFFFF_FFFC);
      cycle();
      $display("t6: req=%0b addr=%h", cap_req, cap_addr);
      chk("t6.req1", 32'(cap_req), 32'h1);
      chk("t6.addr1", cap_addr, 32'h0000_0000);
      run_stream(32'hFFFF_FFFC, 3, "t6");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
